param_counter_hex: RTL and testbench

//  Parametrised synchronous up/down counter with modulus, parallel load and terminal-count pulse.

---
 rtl/counter_pkg.sv | 29 ++
 rtl/param_counter_hex_if.sv | 26 ++
 rtl/param_counter_hex_seg7.sv | 32 +++
 rtl/param_counter_hex.sv | 91 +++++++++
 tb/tb_param_counter_hex.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/counter_pkg.sv
// Shared types and glyph constants for the hex counter and its 7-segment decoder.
// Glyphs are active-low: bit0 = seg a .. bit6 = seg g.
package counter_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_0 = 7'b1000000;
  localparam seg7_t SEG_1 = 7'b1111001;
  localparam seg7_t SEG_2 = 7'b0100100;
  localparam seg7_t SEG_3 = 7'b0110000;
  localparam seg7_t SEG_4 = 7'b0011001;
  localparam seg7_t SEG_5 = 7'b0010010;
  localparam seg7_t SEG_6 = 7'b0000010;
  localparam seg7_t SEG_7 = 7'b1111000;
  localparam seg7_t SEG_8 = 7'b0000000;
  localparam seg7_t SEG_9 = 7'b0010000;
  localparam seg7_t SEG_A = 7'b0001000;
  localparam seg7_t SEG_B = 7'b0000011;
  localparam seg7_t SEG_C = 7'b1000110;
  localparam seg7_t SEG_D = 7'b0100001;
  localparam seg7_t SEG_E = 7'b0000110;
  localparam seg7_t SEG_F = 7'b0001110;

  // Width must split evenly into display nibbles.
  function automatic bit is_mult4(input int width);
    return (width % 4) == 0;
  endfunction

endpackage

// File: rtl/param_counter_hex_if.sv
// Control/status bundle between the board inputs and the hex counter.
// master = whoever drives the controls, slave = the counter itself.
interface param_counter_hex_if #(
  parameter int WIDTH = 8
);
  localparam int NUM_DIGITS = WIDTH / 4;

  logic                      enable;
  logic                      up_down;
  logic                      load;
  logic [WIDTH-1:0]          load_value;
  logic [WIDTH-1:0]          count;
  logic                      tc;
  logic [7*NUM_DIGITS-1:0]   hex;

  modport master (
    output enable, up_down, load, load_value,
    input  count, tc, hex
  );

  modport slave (
    input  enable, up_down, load, load_value,
    output count, tc, hex
  );

endinterface

// File: rtl/param_counter_hex_seg7.sv
// Combinational nibble -> active-low 7-segment glyph (full hex 0-F).
module hex_to_seg7
  import counter_pkg::*;
(
  input  logic [3:0] nibble,
  output seg7_t      seg
);

  always_comb begin
    seg = SEG_0;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_0;
    endcase
  end

endmodule

// File: rtl/param_counter_hex.sv
// Modulus up/down counter with clamped parallel load, terminal-count pulse and
// registered hex display. Define COUNTER_SATURATE_EN to hold at the limits instead of wrapping.
module param_counter_hex
  import counter_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 2**WIDTH
)(
  input  logic                 clock,
  input  logic                 reset,
  param_counter_hex_if.slave   bus
);

  localparam int NUM_DIGITS = WIDTH / 4;

  if (!is_mult4(WIDTH) || WIDTH < 4 || WIDTH > 24) begin : g_bad_width
    $error("param_counter_hex: WIDTH must be a multiple of 4 in 4..24");
  end
  if (MODULUS < 2 || MODULUS > 2**WIDTH) begin : g_bad_modulus
    $error("param_counter_hex: MODULUS must be in 2..2**WIDTH");
  end

  // One extra bit so MODULUS == 2**WIDTH is representable in the clamp compare.
  localparam logic [WIDTH:0]   MOD_EXT = MODULUS[WIDTH:0];
  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0]            count_q, count_d;
  logic                        tc_q, tc_d;
  seg7_t [NUM_DIGITS-1:0]      seg_d, seg_q;
  logic                        at_max, at_zero;

  assign at_max  = (count_q == MAX_CNT);
  assign at_zero = (count_q == '0);

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (bus.load) begin
      count_d = ({1'b0, bus.load_value} >= MOD_EXT) ? MAX_CNT : bus.load_value;
    end else if (bus.enable) begin
      if (bus.up_down) begin
        if (at_max) begin
          tc_d = 1'b1;
`ifdef COUNTER_SATURATE_EN
          count_d = MAX_CNT;
`else
          count_d = '0;
`endif
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (at_zero) begin
          tc_d = 1'b1;
`ifdef COUNTER_SATURATE_EN
          count_d = '0;
`else
          count_d = MAX_CNT;
`endif
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  // Decoders look at the registered count, so the display trails count by one edge.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    hex_to_seg7 u_dec (
      .nibble (count_q[4*g +: 4]),
      .seg    (seg_d[g])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      seg_q   <= {NUM_DIGITS{SEG_0}};
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      seg_q   <= seg_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.hex   = seg_q;

endmodule

// File: tb/tb_param_counter_hex.sv
// Bench for param_counter_hex: three configurations (8-bit full range, mod-10, 4-bit)
// share one stimulus stream and are checked every cycle against an arithmetic model.
module tb_param_counter_hex;

`ifdef COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       up_down = 1'b1;
  logic       load = 1'b0;
  logic [7:0] load_value = 8'h00;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  param_counter_hex_if #(.WIDTH(8)) ifa ();
  param_counter_hex_if #(.WIDTH(8)) ifb ();
  param_counter_hex_if #(.WIDTH(4)) ifc ();

  assign ifa.enable = enable;  assign ifa.up_down = up_down;
  assign ifa.load = load;      assign ifa.load_value = load_value;
  assign ifb.enable = enable;  assign ifb.up_down = up_down;
  assign ifb.load = load;      assign ifb.load_value = load_value;
  assign ifc.enable = enable;  assign ifc.up_down = up_down;
  assign ifc.load = load;      assign ifc.load_value = load_value[3:0];

  param_counter_hex #(.WIDTH(8))                dut_a (.clock(clock), .reset(reset), .bus(ifa));
  param_counter_hex #(.WIDTH(8), .MODULUS(10))  dut_b (.clock(clock), .reset(reset), .bus(ifb));
  param_counter_hex #(.WIDTH(4))                dut_c (.clock(clock), .reset(reset), .bus(ifc));

  // Model: counts as plain integers; glyphs from lit-segment patterns inverted.
  typedef struct packed { int cnt; bit tc; } mstate_t;

  int          mods   [3] = '{256, 10, 16};
  int          widths [3] = '{8, 8, 4};
  int          m_cnt  [3];
  bit          m_tc   [3];
  logic [13:0] m_hex  [3];
  bit          m_valid = 1'b0;

  function automatic logic [6:0] glyph(input int d);
    logic [6:0] lit;
    case (d)
      0: lit = 7'b0111111;  1: lit = 7'b0000110;  2: lit = 7'b1011011;  3: lit = 7'b1001111;
      4: lit = 7'b1100110;  5: lit = 7'b1101101;  6: lit = 7'b1111101;  7: lit = 7'b0000111;
      8: lit = 7'b1111111;  9: lit = 7'b1101111; 10: lit = 7'b1110111; 11: lit = 7'b1111100;
     12: lit = 7'b0111001; 13: lit = 7'b1011110; 14: lit = 7'b1111001; default: lit = 7'b1110001;
    endcase
    return ~lit;
  endfunction

  function automatic logic [13:0] show(input int value, input int w);
    logic [13:0] h;
    h = '0;
    h[6:0] = glyph(value % 16);
    if (w > 4) h[13:7] = glyph((value / 16) % 16);
    return h;
  endfunction

  function automatic mstate_t model_next(input int cnt, input int md, input int w,
                                         input bit rst, input bit ld, input bit en,
                                         input bit ud, input int lv);
    int lvm;
    lvm = lv % (1 << w);
    if (rst) return '{cnt: 0, tc: 1'b0};
    if (ld)  return '{cnt: (lvm >= md) ? md - 1 : lvm, tc: 1'b0};
    if (!en) return '{cnt: cnt, tc: 1'b0};
    if (ud) begin
      if (cnt == md - 1) return '{cnt: SAT ? cnt : 0, tc: 1'b1};
      return '{cnt: cnt + 1, tc: 1'b0};
    end
    if (cnt == 0) return '{cnt: SAT ? 0 : md - 1, tc: 1'b1};
    return '{cnt: cnt - 1, tc: 1'b0};
  endfunction

  always @(posedge clock) begin
    for (int i = 0; i < 3; i++) begin
      mstate_t nx;
      nx = model_next(m_cnt[i], mods[i], widths[i], reset, load, enable, up_down, int'(load_value));
      m_cnt[i] <= nx.cnt;
      m_tc[i]  <= nx.tc;
      m_hex[i] <= reset ? show(0, widths[i]) : show(m_cnt[i], widths[i]);
    end
    if (reset) m_valid <= 1'b1;
  end

  task automatic check(input string name, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  int          d_cnt [3];
  int          d_tc  [3];
  logic [13:0] d_hex [3];
  always_comb begin
    d_cnt[0] = int'(ifa.count);  d_tc[0] = int'(ifa.tc);  d_hex[0] = ifa.hex;
    d_cnt[1] = int'(ifb.count);  d_tc[1] = int'(ifb.tc);  d_hex[1] = ifb.hex;
    d_cnt[2] = int'(ifc.count);  d_tc[2] = int'(ifc.tc);  d_hex[2] = {7'b0, ifc.hex};
  end

  always @(negedge clock) begin
    if (m_valid) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("cycle_count[%0d]", i), d_cnt[i], m_cnt[i]);
        check($sformatf("cycle_tc[%0d]", i), d_tc[i], int'(m_tc[i]));
        check($sformatf("cycle_hex[%0d]", i), int'(d_hex[i]), int'(m_hex[i]));
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int pulses;

    // reset state
    reset = 1'b1; tick();
    check("reset_count_a", int'(ifa.count), 0);
    check("reset_tc_a", int'(ifa.tc), 0);
    check("reset_hex_a", int'(ifa.hex), int'(14'b1000000_1000000));
    check("reset_hex_c", int'(ifc.hex), int'(7'b1000000));

    // full-range up count with a single wrap pulse
    reset = 1'b0; enable = 1'b1; up_down = 1'b1;
    pulses = 0;
    for (int k = 1; k <= 256; k++) begin
      tick();
      if (ifa.tc) pulses++;
      if (k == 255) check("up255_count_a", int'(ifa.count), 255);
    end
    check("wrap_count_a", int'(ifa.count), 0);
    check("wrap_tc_a", int'(ifa.tc), 1);
    check("wrap_pulses_a", pulses, 1);

    // mod-10 up wrap, then down wrap from 0
    reset = 1'b1; enable = 1'b0; tick();
    reset = 1'b0; enable = 1'b1; up_down = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    check("mod10_up_count", int'(ifb.count), 0);
    check("mod10_up_tc", int'(ifb.tc), 1);
    reset = 1'b1; enable = 1'b0; tick();
    reset = 1'b0; enable = 1'b1; up_down = 1'b0; tick();
    check("mod10_down_count", int'(ifb.count), 9);
    check("mod10_down_tc", int'(ifb.tc), 1);
    check("full_down_count_a", int'(ifa.count), 255);

    // clamped load beats enable
    load = 1'b1; load_value = 8'd200; enable = 1'b1; tick();
    check("clamp_count_b", int'(ifb.count), 9);
    check("clamp_tc_b", int'(ifb.tc), 0);
    check("load_count_a", int'(ifa.count), 200);
    check("model_clamp_b", m_cnt[1], 9);

    // direction flips every edge; the model follows each step
    load = 1'b0;
    for (int k = 0; k < 6; k++) begin
      up_down = ~up_down; tick();
    end

    // reset wins over load and enable mid-count
    load = 1'b1; load_value = 8'h5A; enable = 1'b0; tick();
    check("load5a_count_a", int'(ifa.count), 8'h5A);
    reset = 1'b1; load = 1'b1; enable = 1'b1; tick();
    check("midreset_count_a", int'(ifa.count), 0);
    check("midreset_tc_a", int'(ifa.tc), 0);
    reset = 1'b0; load = 1'b0; enable = 1'b0; tick();
    check("midreset_hex_a", int'(ifa.hex), int'(14'b1000000_1000000));

    // hex trails count by one edge
    load = 1'b1; load_value = 8'hB3; tick();
    check("b3_count_a", int'(ifa.count), 8'hB3);
    load = 1'b0; tick();
    check("b3_hex_a", int'(ifa.hex), int'({7'b0000011, 7'b0110000}));
    check("model_b3_hex", int'(m_hex[0]), int'({7'b0000011, 7'b0110000}));

    // 4-bit counter at the top and bottom limits
    load = 1'b1; load_value = 8'd14; tick();
    check("c_load14", int'(ifc.count), 14);
    load = 1'b0; enable = 1'b1; up_down = 1'b1;
    tick();
    check("c_edge1_count", int'(ifc.count), 15);
    check("c_edge1_tc", int'(ifc.tc), 0);
    tick();
    check("c_edge2_count", int'(ifc.count), SAT ? 15 : 0);
    check("c_edge2_tc", int'(ifc.tc), 1);
    tick();
    check("c_edge3_count", int'(ifc.count), SAT ? 15 : 1);
    check("c_edge3_tc", int'(ifc.tc), SAT ? 1 : 0);
    reset = 1'b1; enable = 1'b0; tick();
    reset = 1'b0; enable = 1'b1; up_down = 1'b0; tick();
    check("c_down0_count", int'(ifc.count), SAT ? 0 : 15);
    check("c_down0_tc", int'(ifc.tc), 1);

    // hold: enable low keeps count and clears tc
    enable = 1'b0; tick(); tick();
    check("hold_tc_c", int'(ifc.tc), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
